key_presser: RTL

KEY_PRESSER -- requirements
Module: key_presser

---
 rtl/key_presser.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/key_presser.sv
// Plays a four-symbol guess on a 3-bit button bus, then times the checked
// device's success/fail verdict, with a cycle-count timeout.
module key_presser #(
    parameter int unsigned CLK_FREQUENCY  = 50_000_000,
    parameter int unsigned PRESS_US       = 2_000,
    parameter int unsigned GAP_US         = 2_000,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  guess,
    input  logic        success,
    input  logic        fail,
    output logic [2:0]  btn,
    output logic        busy,
    output logic        done,
    output logic        result_success,
    output logic        timeout,
    output logic [31:0] elapsed
);

    localparam int unsigned CYC_PER_US   = CLK_FREQUENCY / 1_000_000;
    localparam int unsigned PRESS_RAW    = CYC_PER_US * PRESS_US;
    localparam int unsigned GAP_RAW      = CYC_PER_US * GAP_US;
    localparam int unsigned PRESS_CYCLES = (PRESS_RAW == 0) ? 1 : PRESS_RAW;
    localparam int unsigned GAP_CYCLES   = (GAP_RAW == 0) ? 1 : GAP_RAW;
    localparam int unsigned TIMEOUT_LIM  = (TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRESS   = 3'd1,
        RELEASE = 3'd2,
        MEASURE = 3'd3,
        DONE    = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  guess_q, guess_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  btn_q, btn_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        res_q, res_d;
    logic        tmo_q, tmo_d;
    logic [31:0] elapsed_q, elapsed_d;
    logic [1:0]  sym_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            guess_q   <= 8'd0;
            idx_q     <= 2'd0;
            cnt_q     <= 32'd0;
            btn_q     <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            res_q     <= 1'b0;
            tmo_q     <= 1'b0;
            elapsed_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            guess_q   <= guess_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            btn_q     <= btn_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            res_q     <= res_d;
            tmo_q     <= tmo_d;
            elapsed_q <= elapsed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        guess_d   = guess_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        tmo_d     = tmo_q;
        elapsed_d = elapsed_q;
        sym_d     = 2'd0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    guess_d   = guess;
                    idx_d     = 2'd0;
                    cnt_d     = 32'd0;
                    res_d     = 1'b0;
                    tmo_d     = 1'b0;
                    elapsed_d = 32'd0;
                    state_d   = PRESS;
                end
            end
            PRESS: begin
                if (cnt_q == 32'(PRESS_CYCLES - 1)) begin
                    cnt_d   = 32'd0;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RELEASE: begin
                if (cnt_q == 32'(GAP_CYCLES - 1)) begin
                    cnt_d = 32'd0;
                    if (idx_q == 2'd3) begin
                        state_d = MEASURE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = PRESS;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            MEASURE: begin
                // A simultaneous success and fail resolves as success.
                if (success || fail) begin
                    elapsed_d = cnt_q;
                    res_d     = success;
                    state_d   = DONE;
                end else if (cnt_q == 32'(TIMEOUT_LIM - 1)) begin
                    tmo_d     = 1'b1;
                    res_d     = 1'b0;
                    elapsed_d = 32'(TIMEOUT_LIM);
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            DONE: begin
                cnt_d   = 32'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        case (idx_d)
            2'd0:    sym_d = guess_d[7:6];
            2'd1:    sym_d = guess_d[5:4];
            2'd2:    sym_d = guess_d[3:2];
            default: sym_d = guess_d[1:0];
        endcase
        btn_d  = (state_d == PRESS) ? {1'b1, sym_d} : 3'b000;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign btn            = btn_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign result_success = res_q;
    assign timeout        = tmo_q;
    assign elapsed        = elapsed_q;

endmodule
